// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front end: deserialises cmd+payload frames from MOSI,
// serialises read data onto MISO, and flags aborted or timed-out frames.
module spi_slave_param #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int N  = DATA_W + 2;
  localparam int CW = $clog2(N + 1);
  localparam int TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    WAIT_TX,
    SHIFT_OUT,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [TW-1:0]     wcnt, wcnt_n;
  logic [DATA_W-2:0] shreg, shreg_n;
  logic              addr_held, addr_held_n;
  logic [N-1:0]      rx_data_n;
  logic              miso_n, rx_valid_n, frame_err_n;

  assign busy = (state != IDLE);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    wcnt_n      = '0;
    shreg_n     = shreg;
    addr_held_n = addr_held;
    rx_data_n   = rx_data;
    miso_n      = 1'b0;
    rx_valid_n  = 1'b0;
    frame_err_n = 1'b0;

    // Deselect wins over every other transition, including a completing word.
    if (state != IDLE && SS_n) begin
      state_n     = IDLE;
      cnt_n       = '0;
      frame_err_n = (state != DONE);
    end else begin
      unique case (state)
        IDLE: begin
          if (!SS_n) state_n = CHK_CMD;
        end

        CHK_CMD: begin
          cnt_n = CW'(N);
          if (!MOSI)          state_n = WRITE;
          else if (addr_held) state_n = READ_DATA;
          else                state_n = READ_ADD;
        end

        WRITE, READ_ADD, READ_DATA: begin
          if (cnt != '0) begin
            for (int i = 0; i < N; i++) begin
              if (cnt == CW'(i + 1)) rx_data_n[i] = MOSI;
            end
            cnt_n = cnt - 1'b1;
          end else begin
            rx_valid_n = 1'b1;
            if (state == WRITE) begin
              state_n = DONE;
            end else if (state == READ_ADD) begin
              addr_held_n = 1'b1;
              state_n     = DONE;
            end else begin
              state_n = WAIT_TX;
            end
          end
        end

        WAIT_TX: begin
          if (tx_valid) begin
            shreg_n = tx_data[DATA_W-2:0];
            miso_n  = tx_data[DATA_W-1];
            cnt_n   = CW'(DATA_W - 1);
            state_n = SHIFT_OUT;
          end else if (TX_TIMEOUT != 0 && wcnt == TW'(TX_TIMEOUT - 1)) begin
            frame_err_n = 1'b1;
            state_n     = DONE;
          end else begin
            wcnt_n = wcnt + 1'b1;
          end
        end

        SHIFT_OUT: begin
          // cnt counts the bits still to drive; the MSB left with the load.
          if (cnt != '0) begin
            for (int i = 0; i < DATA_W - 1; i++) begin
              if (cnt == CW'(i + 1)) miso_n = shreg[i];
            end
            cnt_n = cnt - 1'b1;
          end else begin
            addr_held_n = 1'b0;
            state_n     = DONE;
          end
        end

        DONE: begin
          state_n = DONE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      wcnt      <= '0;
      shreg     <= '0;
      addr_held <= 1'b0;
      rx_data   <= '0;
      MISO      <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      wcnt      <= wcnt_n;
      shreg     <= shreg_n;
      addr_held <= addr_held_n;
      rx_data   <= rx_data_n;
      MISO      <= miso_n;
      rx_valid  <= rx_valid_n;
      frame_err <= frame_err_n;
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed scoreboard bench for spi_slave_param: an 8-bit instance (a) and a
// 16-bit instance (b), driven one at a time from a single linear sequence.
module tb_spi_slave_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ss_n_a, mosi_a, miso_a, rx_valid_a, tx_valid_a, frame_err_a, busy_a;
  logic [9:0]  rx_data_a;
  logic [7:0]  tx_data_a;
  logic        ss_n_b, mosi_b, miso_b, rx_valid_b, tx_valid_b, frame_err_b, busy_b;
  logic [17:0] rx_data_b;
  logic [15:0] tx_data_b;

  int passed = 0;
  int total  = 0;

  logic [17:0] rx_q[$];
  logic        bit_q[$];

  always #5 clk = ~clk;

  spi_slave_param #(.DATA_W(8), .TX_TIMEOUT(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n_a), .MOSI(mosi_a), .MISO(miso_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .frame_err(frame_err_a), .busy(busy_a)
  );

  spi_slave_param #(.DATA_W(16), .TX_TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n_b), .MOSI(mosi_b), .MISO(miso_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .frame_err(frame_err_b), .busy(busy_b)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit wide, logic ss, logic mosi);
    if (wide) begin ss_n_b = ss; mosi_b = mosi; end
    else      begin ss_n_a = ss; mosi_a = mosi; end
  endtask

  task automatic set_tx(bit wide, logic valid, logic [15:0] data);
    if (wide) begin tx_valid_b = valid; tx_data_b = data; end
    else      begin tx_valid_a = valid; tx_data_a = data[7:0]; end
  endtask

  function automatic logic rxv(bit wide);
    return wide ? rx_valid_b : rx_valid_a;
  endfunction

  function automatic logic [17:0] rxd(bit wide);
    return wide ? rx_data_b : {8'h00, rx_data_a};
  endfunction

  function automatic logic miso(bit wide);
    return wide ? miso_b : miso_a;
  endfunction

  function automatic logic ferr(bit wide);
    return wide ? frame_err_b : frame_err_a;
  endfunction

  task automatic start_frame(bit wide, logic sel);
    drive(wide, 1'b0, 1'b0); step();   // E0
    drive(wide, 1'b0, sel);  step();   // E1: selector
  endtask

  task automatic shift_bits(bit wide, logic [17:0] word, int nbits, int count);
    for (int i = 0; i < count; i++) begin
      drive(wide, 1'b0, word[nbits-1-i]);
      step();
    end
  endtask

  task automatic end_frame(bit wide, string tag);
    drive(wide, 1'b1, 1'b0); step();
    check({tag, "_end_rxv"}, rxv(wide), 1'b0);
    check({tag, "_end_ferr"}, ferr(wide), 1'b0);
  endtask

  task automatic full_frame(bit wide, logic sel, logic [17:0] word, string tag);
    int n;
    logic [17:0] exp;
    n = wide ? 18 : 10;
    rx_q.push_back(word);
    start_frame(wide, sel);
    shift_bits(wide, word, n, n);
    drive(wide, 1'b0, 1'b0); step();   // E(N+2)
    check({tag, "_rx_valid"}, rxv(wide), 1'b1);
    exp = (rx_q.size() > 0) ? rx_q.pop_front() : 18'h0;
    check({tag, "_rx_data"}, rxd(wide), exp);
  endtask

  task automatic read_out(bit wide, logic [15:0] data, string tag);
    int  w;
    logic eb;
    w = wide ? 16 : 8;
    for (int i = w - 1; i >= 0; i--) bit_q.push_back(data[i]);
    set_tx(wide, 1'b1, data); step();  // Ek
    set_tx(wide, 1'b0, 16'h0000);
    for (int i = 0; i < w; i++) begin
      eb = (bit_q.size() > 0) ? bit_q.pop_front() : 1'b0;
      check($sformatf("%s_bit%0d", tag, w - 1 - i), miso(wide), eb);
      step();
    end
    check({tag, "_miso_after"}, miso(wide), 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] prev_w, abort_w;
    int seen;
    logic miso_seen;

    rst_n = 1'b0;
    drive(0, 1'b1, 1'b0);
    drive(1, 1'b1, 1'b0);
    set_tx(0, 1'b0, 16'h0);
    set_tx(1, 1'b0, 16'h0);
    step(); step();
    check("rst_miso", miso_a, 1'b0);
    check("rst_rxv", rx_valid_a, 1'b0);
    check("rst_ferr", frame_err_a, 1'b0);
    check("rst_rxdata", rx_data_a, 10'h000);
    check("rst_busy", busy_a, 1'b0);
    check("rst_held", dut_a.addr_held, 1'b0);
    check("rst_busy_b", busy_b, 1'b0);
    rst_n = 1'b1;
    step();

    // Write-address frame; tx_valid held high throughout and must be ignored.
    set_tx(0, 1'b1, 16'h005A);
    full_frame(0, 1'b0, 18'h0A5, "wr_addr");
    check("wr_addr_miso", miso_a, 1'b0);
    check("wr_addr_ferr", frame_err_a, 1'b0);
    set_tx(0, 1'b0, 16'h0);
    end_frame(0, "wr_addr");
    check("wr_addr_idle", busy_a, 1'b0);

    // Read-address then read-data.
    full_frame(0, 1'b1, 18'h23C, "rd_addr");
    check("rd_addr_held", dut_a.addr_held, 1'b1);
    end_frame(0, "rd_addr");
    full_frame(0, 1'b1, 18'h300, "rd_data");
    check("rd_data_busy", busy_a, 1'b1);
    read_out(0, 16'h00C3, "rd_c3");
    check("rd_c3_held_clr", dut_a.addr_held, 1'b0);
    end_frame(0, "rd_c3");
    check("rd_c3_idle", busy_a, 1'b0);

    // Abort after 5 payload bits of a write.
    prev_w  = 10'h300;
    abort_w = 10'h3FF;
    start_frame(0, 1'b0);
    shift_bits(0, {8'h00, abort_w}, 10, 5);
    drive(0, 1'b1, 1'b0); step();
    check("abort_ferr", frame_err_a, 1'b1);
    check("abort_rxv", rx_valid_a, 1'b0);
    check("abort_idle", busy_a, 1'b0);
    check("abort_rxdata", rx_data_a, {abort_w[9:5], prev_w[4:0]});
    step();
    check("abort_ferr_pulse", frame_err_a, 1'b0);

    // SS_n rises on the very edge the counter reaches 0.
    start_frame(0, 1'b0);
    shift_bits(0, 18'h155, 10, 10);
    drive(0, 1'b1, 1'b0); step();
    check("sim_rxv", rx_valid_a, 1'b0);
    check("sim_ferr", frame_err_a, 1'b1);
    check("sim_rxdata", rx_data_a, 10'h155);
    step();

    // tx_valid timeout in a read-data frame.
    full_frame(0, 1'b1, 18'h211, "rd_addr2");
    end_frame(0, "rd_addr2");
    full_frame(0, 1'b1, 18'h3AA, "to");
    seen = 0;
    miso_seen = 1'b0;
    for (int c = 1; c <= 20 && seen == 0; c++) begin
      step();
      miso_seen = miso_seen | miso_a;
      if (frame_err_a) seen = c;
    end
    check("to_cycle", seen, 16);
    check("to_miso", miso_seen, 1'b0);
    check("to_held", dut_a.addr_held, 1'b1);
    check("to_busy", busy_a, 1'b1);
    end_frame(0, "to");

    // Reset in the middle of SHIFT_OUT.
    full_frame(0, 1'b1, 18'h396, "rst_rd");
    set_tx(0, 1'b1, 16'h0096); step();
    set_tx(0, 1'b0, 16'h0);
    check("rst_rd_bit7", miso_a, 1'b1);
    step();
    check("rst_rd_bit6", miso_a, 1'b0);
    step();
    check("rst_rd_bit5", miso_a, 1'b0);
    rst_n = 1'b0;
    step();
    check("midrst_miso", miso_a, 1'b0);
    check("midrst_rxv", rx_valid_a, 1'b0);
    check("midrst_ferr", frame_err_a, 1'b0);
    check("midrst_rxdata", rx_data_a, 10'h000);
    check("midrst_busy", busy_a, 1'b0);
    check("midrst_held", dut_a.addr_held, 1'b0);
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0); step();
    full_frame(0, 1'b1, 18'h3F0, "post_rst");
    check("post_rst_held", dut_a.addr_held, 1'b1);
    end_frame(0, "post_rst");

    // Wide instance, DATA_W=16.
    full_frame(1, 1'b1, 18'h21234, "w_addr");
    check("w_addr_held", dut_b.addr_held, 1'b1);
    end_frame(1, "w_addr");
    full_frame(1, 1'b1, 18'h30000, "w_data");
    read_out(1, 16'hA55A, "w_a55a");
    check("w_held_clr", dut_b.addr_held, 1'b0);
    end_frame(1, "w_a55a");
    check("w_idle", busy_b, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
# spi_slave_param

Parametrised SPI slave front end that sits between the SPI pins and the RAM-side word interface. It is the successor of the fixed 10-bit slave. It adds:
- a configurable data width,
- a single-cycle `rx_valid` pulse,
- an explicit post-frame state,
- a `tx_valid` wait timeout,
- a frame-error flag for aborted transfers.

The SPI bit clock is the system `clk`. `MOSI` is sampled, and `MISO` driven, on `clk` rising edges while `SS_n` is low.

## Interface
- `DATA_W`, default 8 – payload/data width, ≥2; frame word is `DATA_W+2` bits (2-bit cmd + payload).
- `TX_TIMEOUT`, default 16 – max cycles to wait for `tx_valid` in a read-data frame; 0 disables the timeout.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `SS_n`  in  1  slave select, active-low; frame delimiter.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial data out, MSB first; 0 when not shifting.
- `rx_data`  out  `DATA_W+2`  received word; `[DATA_W+1:DATA_W]` = cmd (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data).
- `rx_valid`  out  1  one-cycle pulse: `rx_data` complete.
- `tx_data`  in  `DATA_W`  read data from the memory side.
- `tx_valid`  in  1  `tx_data` valid; sampled only in WAIT_TX.
- `frame_err`  out  1  one-cycle pulse: frame aborted or `tx_valid` timeout.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Let N = `DATA_W+2`. The bit counter is `$clog2(N+1)` bits wide. `addr_held` is an internal flag.
- **States:** IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SHIFT_OUT, DONE.
- **IDLE:**
  - `SS_n`=0 → CHK_CMD.
  - `rx_valid`=0 and `MISO`=0.
- **CHK_CMD:** samples the selector bit on `MOSI`; this bit is not stored.
  - Selector 0 → WRITE.
  - Selector 1 with `addr_held`=0 → READ_ADD.
  - Selector 1 with `addr_held`=1 → READ_DATA.
  - Counter loads N.
- **WRITE / READ_ADD / READ_DATA:**
  - While counter>0, shift `MOSI` into `rx_data[counter-1]` and decrement.
  - At counter==0, pulse `rx_valid` for one cycle.
  - WRITE → DONE.
  - READ_ADD sets `addr_held` and → DONE.
  - READ_DATA → WAIT_TX.
- **WAIT_TX:**
  - On `tx_valid`=1: latch `tx_data` into the shift register, drive `MISO`=`tx_data[DATA_W-1]`, → SHIFT_OUT.
  - If `TX_TIMEOUT`≠0 and `TX_TIMEOUT` cycles elapse with `tx_valid` low: pulse `frame_err`, → DONE. `addr_held` is unchanged.
- **SHIFT_OUT:**
  - Drives the remaining `DATA_W-1` bits, one per cycle, MSB first.
  - The cycle after the last bit: `MISO`=0, `addr_held` cleared, → DONE.
- **DONE:** ignores `MOSI`, `MISO`=0, waits for `SS_n`=1.
- **`SS_n`=1 sampled in any non-IDLE state:**
  - → IDLE next cycle; counter cleared, `MISO`=0.
  - `frame_err` pulses that cycle unless the state is DONE.
  - `addr_held` and `rx_data` are unchanged.
- **`rx_data`** holds its last value until overwritten by the next shifted bit. A partially shifted word is never flagged valid.
- **`tx_valid`** outside WAIT_TX is ignored.

## Timing
- **Reset (`rst_n`=0 at an edge):**
  - State → IDLE and `addr_held` → 0.
  - `MISO`, `rx_valid`, `frame_err` → 0; `rx_data` → 0; `busy` → 0.
  - Reset mid-frame aborts with no `frame_err`.
- **Frame timing:** E0 is the first edge that samples `SS_n`=0 in IDLE.
  - Selector is sampled at E1.
  - Payload bits are sampled at E2..E(N+1).
  - `rx_valid` is high for exactly the cycle after E(N+2).
- **Read data:** `tx_valid` is sampled high at edge Ek.
  - `MISO`=bit `DATA_W-1` after Ek.
  - Bit i appears after Ek+(`DATA_W-1-i`).
  - `MISO`=0 after Ek+`DATA_W`.
- **Simultaneous events:** `SS_n` rising takes priority over every other transition, including `tx_valid` and the counter reaching 0. In that cycle `rx_valid` is not asserted.
- **Back-to-back frames:** `SS_n` high for one sampled cycle is sufficient between frames.

## Test plan
- **Write-address frame:** DATA_W=8; `SS_n` low, selector 0, then `MOSI` 10'b00_1010_0101 → `rx_data`=10'h0A5 and `rx_valid` high for one cycle after E12; `frame_err`=0.
- **Read-address then read-data:**
  - Frame 1: selector 1, 10'h2_3C → READ_ADD, `addr_held`=1.
  - Frame 2: selector 1, 10'h3_00, `tx_valid`=1 with `tx_data`=8'hC3 → `MISO`=1,1,0,0,0,0,1,1; `addr_held` cleared.
- **Abort:** `SS_n` rises after 5 payload bits of a write → `frame_err` pulses once, no `rx_valid`, state IDLE next cycle.
- **Timeout:** read-data frame with `tx_valid` held low, `TX_TIMEOUT`=16 → `frame_err` 16 cycles after entering WAIT_TX, `MISO` stays 0, `addr_held` still 1.
- **Reset mid-shift-out:** `rst_n`=0 during SHIFT_OUT → all outputs 0 next cycle, `addr_held`=0; the next selector-1 frame goes to READ_ADD.
- **Wide instance:** DATA_W=16 (N=18); read-data frame with `tx_data`=16'hA55A → 16 `MISO` bits, MSB first, matching the value.
